// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a byte FIFO; back-to-back frames are sent
// without an idle gap while the FIFO holds data.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    output logic                        serialOut,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        busy,
    output logic                        overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              r_state, w_next_state;
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]      r_count;
    logic                r_overflow;
    logic [7:0]          r_shift;
    logic [2:0]          r_bit_cnt;
    logic [BAUD_W-1:0]   r_baud;
    logic                r_serial;
    logic                w_push, w_pop, w_bit_done, w_tx_bit, w_busy;

    assign full       = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty      = (r_count == '0);
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign serialOut  = r_serial;
    assign busy       = w_busy;

    assign w_bit_done = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_push     = wr_en && !full;
    // The head is popped from IDLE, or at the last stop-bit cycle so the next start bit follows directly.
    assign w_pop      = !empty && ((r_state == IDLE) || (r_state == STOP && w_bit_done));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (wr_en && full) r_overflow <= 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (!empty) w_next_state = START;
            START: if (w_bit_done) w_next_state = DATA;
            DATA:  if (w_bit_done && r_bit_cnt == 3'd7) w_next_state = STOP;
            STOP:  if (w_bit_done) w_next_state = empty ? IDLE : START;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_tx_bit = 1'b1;
        w_busy   = (r_state != IDLE);
        case (r_state)
            START:   w_tx_bit = 1'b0;
            DATA:    w_tx_bit = r_shift[0];
            default: w_tx_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_baud    <= '0;
        end else if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_bit_cnt <= '0;
            r_baud    <= '0;
        end else if (r_state != IDLE) begin
            r_baud <= w_bit_done ? '0 : r_baud + 1'b1;
            if (r_state == DATA && w_bit_done) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // Line level is re-timed through a flop so bit transitions are glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_serial <= 1'b1;
        else       r_serial <= w_tx_bit;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random pushes,
// compared every cycle against a queue-and-frame-position reference model.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       serialOut, full, empty, busy, overflow;
    logic [3:0] count;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .serialOut (serialOut),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .busy      (busy),
        .overflow  (overflow)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: pending bytes, position inside the current frame (-1 = none),
    // byte being sent, sticky overflow and the expected registered line level.
    logic [7:0] m_q[$];
    int         m_pos;
    logic [7:0] m_cur;
    logic       m_ovf;
    logic       m_serial;

    function automatic logic line_level(input int pos, input logic [7:0] b);
        int idx;
        if (pos < 0) return 1'b1;
        idx = pos / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".serial"},   32'(serialOut), 32'(m_serial));
        check({tag, ".busy"},     32'(busy),      32'(m_pos >= 0));
        check({tag, ".count"},    32'(count),     32'(m_q.size()));
        check({tag, ".full"},     32'(full),      32'(m_q.size() == DEPTH));
        check({tag, ".empty"},    32'(empty),     32'(m_q.size() == 0));
        check({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pos    = -1;
        m_cur    = 8'h00;
        m_ovf    = 1'b0;
        m_serial = 1'b1;
    endtask

    task automatic model_edge(input logic we, input logic [7:0] d);
        logic lvl;
        logic was_full;
        logic pop;
        lvl      = line_level(m_pos, m_cur);
        was_full = (m_q.size() == DEPTH);
        pop      = (m_q.size() > 0) && (m_pos < 0 || m_pos == FRAME - 1);
        if (pop) begin
            m_cur = m_q.pop_front();
            m_pos = 0;
        end else if (m_pos >= 0) begin
            m_pos++;
            if (m_pos == FRAME) m_pos = -1;
        end
        if (we) begin
            if (was_full) m_ovf = 1'b1;
            else          m_q.push_back(d);
        end
        m_serial = lvl;
    endtask

    task automatic tick(input logic we, input logic [7:0] d, input string tag);
        wr_en   = we;
        wr_data = we ? d : 8'($urandom);
        @(posedge clk);
        model_edge(we, d);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, tag);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        wr_en = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".assert"});
        repeat (2) @(negedge clk);
        check_all({tag, ".hold"});
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        model_reset();
        #1 reset = 1'b1;
        #1 check_all("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(3, "idle0");

        // Single byte from idle: start bit two edges after the push.
        tick(1'b1, 8'hA5, "a5_push");
        tick(1'b0, 8'h00, "a5_e1");
        check("a5_busy_e1", 32'(busy), 32'd1);
        check("a5_high_e1", 32'(serialOut), 32'd1);
        tick(1'b0, 8'h00, "a5_e2");
        check("a5_low_e2", 32'(serialOut), 32'd0);
        idle(44, "a5_frame");
        check("a5_done_empty", 32'(empty), 32'd1);
        check("a5_done_busy",  32'(busy),  32'd0);

        // Three bytes back to back: contiguous frames.
        tick(1'b1, 8'h00, "b2b_0");
        tick(1'b1, 8'hFF, "b2b_1");
        tick(1'b1, 8'h3C, "b2b_2");
        idle(FRAME * 3 + 5, "b2b_frames");

        // Ten consecutive pushes: ninth fills the FIFO, tenth is dropped.
        apply_reset("rst_ovf");
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 8'($urandom), "burst");
            if (i == 9) begin
                check("burst_cnt9",  32'(count), 32'd8);
                check("burst_full9", 32'(full),  32'd1);
                check("burst_ovf9",  32'(overflow), 32'd0);
            end
        end
        check("burst_ovf10", 32'(overflow), 32'd1);
        idle(FRAME * 9 + 10, "burst_drain");
        check("burst_ovf_sticky", 32'(overflow), 32'd1);

        // Push rejected on the same edge that the stop bit pops the head.
        apply_reset("rst_edge");
        for (int i = 0; i < 9; i++) tick(1'b1, 8'($urandom), "edge_fill");
        idle(32, "edge_wait");
        check("edge_pre_cnt", 32'(count), 32'd8);
        tick(1'b1, 8'hEE, "edge_push");
        check("edge_cnt7", 32'(count), 32'd7);
        check("edge_ovf",  32'(overflow), 32'd1);
        idle(FRAME * 8 + 10, "edge_drain");

        // Reset mid-frame during data bit 3 of 0x55 with four bytes queued.
        apply_reset("rst_mid_pre");
        tick(1'b1, 8'h55, "mid_push");
        for (int i = 0; i < 4; i++) tick(1'b1, 8'($urandom), "mid_queue");
        idle(14, "mid_run");
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_serial", 32'(serialOut), 32'd1);
        check("mid_count",  32'(count),     32'd0);
        check("mid_empty",  32'(empty),     32'd1);
        check("mid_busy",   32'(busy),      32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle(60, "mid_quiet");

        // Random traffic with varying push density.
        for (int phase = 0; phase < 4; phase++) begin
            for (int i = 0; i < 150; i++) begin
                logic we;
                we = ($urandom_range(0, 7) < (phase * 2 + 1));
                tick(we, 8'($urandom), "rand");
            end
        end
        idle(FRAME * (DEPTH + 1) + 5, "rand_drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, byte entries; power of two, 2..64.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 wr_en  input  1  push request for wr_data; sampled on the rising edge.
REQ-006 wr_data  input  8  byte to transmit.
REQ-007 serialOut  output  1  UART TX line, idle high, registered.
REQ-008 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-009 empty  output  1  FIFO holds 0 entries.
REQ-010 count  output  clog2(FIFO_DEPTH)+1  number of FIFO entries.
REQ-011 busy  output  1  high when the transmit FSM is not in IDLE.
REQ-012 overflow  output  1  sticky; set when a push is rejected.

Function
REQ-013 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-014 Push SHALL be accepted when wr_en=1 and full=0 as seen before the edge; wr_en=1 with full=1 SHALL drop the byte and set overflow, even if a pop occurs on the same edge.
REQ-015 Simultaneous accepted push and pop SHALL leave count unchanged; FIFO order SHALL be strict first-in first-out; read/write pointers wrap modulo FIFO_DEPTH.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-017 IDLE: serialOut=1; on an edge with empty=0, SHALL pop the head into the shift register, load bit counter 0, clear the baud counter and enter START.
REQ-018 START: serialOut=0 for CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: serialOut = shift register bit 0; after each CLKS_PER_BIT cycles shift right, increment bit counter; after bit 7 completes, enter STOP.
REQ-020 STOP: serialOut=1 for CLKS_PER_BIT cycles; at its final cycle, if empty=0, SHALL pop and go directly to START (no idle gap between frames); else go to IDLE.
REQ-021 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary.
REQ-022 Latency: a push into an empty FIFO with FSM in IDLE SHALL drive serialOut low on the second rising edge after the push edge.
REQ-023 busy SHALL be high from the edge entering START until the edge returning to IDLE.
REQ-024 full, empty, count SHALL reflect the FIFO state after each edge, with no combinational path from wr_en.
REQ-025 serialOut SHALL be driven from a flop; no glitches between bits.

Reset
REQ-026 While reset=1: serialOut=1, busy=0, full=0, empty=1, count=0, overflow=0, FSM=IDLE, pointers and counters 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame, force serialOut=1 without waiting for a clock edge, and discard all FIFO contents.
REQ-028 overflow SHALL clear only via reset.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-029 Push 0xA5 once from idle -> serialOut low 2 edges later, then levels 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 total), busy high for 40 cycles, then empty=1, busy=0.
REQ-030 Push 0x00, 0xFF, 0x3C on consecutive edges -> three contiguous 40-cycle frames (120 cycles), no idle high between stop and next start, data LSB first.
REQ-031 Push on 10 consecutive edges from idle -> first byte popped on edge 2; count=8, full=1 after edge 9; 10th byte dropped, overflow=1; the 9 accepted bytes transmit in order.
REQ-032 Fill to full, then push and end-of-STOP pop on the same edge -> push rejected, overflow=1, count=7.
REQ-033 Assert reset during DATA bit 3 of 0x55 with 4 bytes queued -> serialOut=1 immediately, count=0, empty=1, busy=0; after release, no output until a new push.
